// File: rtl/counter_checker_pkg.sv
// counter_checker_pkg: shared state encoding and default widths for the counter checker
package counter_checker_pkg;
  typedef enum logic [1:0] {IDLE, TRACK, DONE, FAIL} state_t;
  localparam int WIDTH_DEF = 8;
  localparam int ERR_W_DEF = 4;
  localparam int SCW = 16;
endpackage

// File: rtl/counter_track_lane.sv
// counter_track_lane: expected-value tracker for one counter bus
// exp_o exists only with COUNTER_CHECKER_CAPTURE_EN defined
module counter_track_lane #(
  parameter int WIDTH = 8,
  parameter int STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             chk,
  input  logic [WIDTH-1:0] obs,
`ifdef COUNTER_CHECKER_CAPTURE_EN
  output logic [WIDTH-1:0] exp_o,
`endif
  output logic             mis
);
  logic [WIDTH-1:0] exp_q;
  assign mis = chk && obs != exp_q;
`ifdef COUNTER_CHECKER_CAPTURE_EN
  assign exp_o = exp_q;
`endif
  // seeding, advancing and resync all reduce to observed + STEP
  always_ff @(posedge clk or posedge rst)
    if (rst) exp_q <= '0;
    else if (clr) exp_q <= '0;
    else if (load) exp_q <= obs + WIDTH'(STEP);
endmodule

// File: rtl/counter_checker.sv
// counter_checker: checks two free-running counters, flags mismatches, sticky done/fail
// COUNTER_CHECKER_CAPTURE_EN adds first-mismatch capture outputs
module counter_checker
  import counter_checker_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int STEP1 = 1,
  parameter int STEP2 = 2,
  parameter int TARGET2 = 208,
  parameter int MAX_ERR = 4,
  parameter int ERR_W = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic             clear,
  input  logic [WIDTH-1:0] cnt1_in,
  input  logic [WIDTH-1:0] cnt2_in,
`ifdef COUNTER_CHECKER_CAPTURE_EN
  output logic [WIDTH-1:0] first_bad_exp1,
  output logic [WIDTH-1:0] first_bad_obs1,
  output logic [WIDTH-1:0] first_bad_exp2,
  output logic [WIDTH-1:0] first_bad_obs2,
`endif
  output logic             done,
  output logic             fail,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic [SCW-1:0]   sample_count
);
  state_t           state_q;
  logic             done_q, fail_q, mis_q;
  logic [ERR_W-1:0] err_q, err_d;
  logic [SCW-1:0]   cnt_q, cnt_d;
  logic             seed, adv, mis1, mis2, bad, hit;
  assign seed  = sample_en && !clear && state_q == IDLE;
  assign adv   = sample_en && !clear && state_q == TRACK;
  assign bad   = mis1 || mis2;
  assign hit   = cnt2_in == WIDTH'(TARGET2);
  assign err_d = (bad && err_q != '1) ? err_q + 1'b1 : err_q;
  assign cnt_d = (cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
`ifdef COUNTER_CHECKER_CAPTURE_EN
  logic [WIDTH-1:0] exp1, exp2;
  counter_track_lane #(.WIDTH(WIDTH), .STEP(STEP1)) u_lane1 (
    .clk(clk), .rst(rst), .clr(clear), .load(seed || adv), .chk(adv),
    .obs(cnt1_in), .exp_o(exp1), .mis(mis1));
  counter_track_lane #(.WIDTH(WIDTH), .STEP(STEP2)) u_lane2 (
    .clk(clk), .rst(rst), .clr(clear), .load(seed || adv), .chk(adv),
    .obs(cnt2_in), .exp_o(exp2), .mis(mis2));
  logic [WIDTH-1:0] fe1_q, fo1_q, fe2_q, fo2_q;
  // err_q is zero only until the first mismatch since IDLE
  always_ff @(posedge clk or posedge rst)
    if (rst) {fe1_q, fo1_q, fe2_q, fo2_q} <= '0;
    else if (clear) {fe1_q, fo1_q, fe2_q, fo2_q} <= '0;
    else if (adv && bad && err_q == '0) {fe1_q, fo1_q, fe2_q, fo2_q} <= {exp1, cnt1_in, exp2, cnt2_in};
  assign first_bad_exp1 = fe1_q;
  assign first_bad_obs1 = fo1_q;
  assign first_bad_exp2 = fe2_q;
  assign first_bad_obs2 = fo2_q;
`else
  counter_track_lane #(.WIDTH(WIDTH), .STEP(STEP1)) u_lane1 (
    .clk(clk), .rst(rst), .clr(clear), .load(seed || adv), .chk(adv),
    .obs(cnt1_in), .mis(mis1));
  counter_track_lane #(.WIDTH(WIDTH), .STEP(STEP2)) u_lane2 (
    .clk(clk), .rst(rst), .clr(clear), .load(seed || adv), .chk(adv),
    .obs(cnt2_in), .mis(mis2));
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      {done_q, fail_q, mis_q} <= '0;
      err_q <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      state_q <= IDLE;
      {done_q, fail_q, mis_q} <= '0;
      err_q <= '0;
      cnt_q <= '0;
    end else begin
      mis_q <= adv && bad;
      if (seed) begin
        cnt_q <= SCW'(1);
        state_q <= hit ? DONE : TRACK;
        done_q <= hit;
      end
      // FAIL is tested first so it wins over a same-sample target hit
      if (adv) begin
        cnt_q <= cnt_d;
        err_q <= err_d;
        if (err_d >= ERR_W'(MAX_ERR)) begin
          state_q <= FAIL;
          fail_q <= 1'b1;
        end else if (!bad && hit) begin
          state_q <= DONE;
          done_q <= 1'b1;
        end
      end
    end
  assign done = done_q;
  assign fail = fail_q;
  assign mismatch = mis_q;
  assign err_count = err_q;
  assign sample_count = cnt_q;
endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker: directed vectors with a queued scoreboard checking counter_checker
module tb_counter_checker;
  typedef struct {
    string       nm;
    logic        d, f, m;
    logic [3:0]  e;
    logic [15:0] c;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, sample_en = 1'b0, clear = 1'b0;
  logic [7:0] cnt1_in = '0, cnt2_in = '0;
  logic done, fail, mismatch;
  logic [3:0] err_count;
  logic [15:0] sample_count;
  exp_t q[$];
  exp_t cur;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  counter_checker dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .clear(clear),
    .cnt1_in(cnt1_in), .cnt2_in(cnt2_in),
`ifdef COUNTER_CHECKER_CAPTURE_EN
    .first_bad_exp1(), .first_bad_obs1(), .first_bad_exp2(), .first_bad_obs2(),
`endif
    .done(done), .fail(fail), .mismatch(mismatch),
    .err_count(err_count), .sample_count(sample_count));

  function automatic exp_t mk(string nm, logic d, logic f, logic m, int e, int c);
    exp_t r;
    r.nm = nm; r.d = d; r.f = f; r.m = m; r.e = 4'(e); r.c = 16'(c);
    return r;
  endfunction

  task automatic chk(string nm, string fld, logic [15:0] act, logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d at %0t", nm, fld, act, req, $time);
    end
  endtask

  task automatic step(logic en, logic cl, int a, int b, exp_t e);
    @(negedge clk);
    sample_en = en; clear = cl; cnt1_in = 8'(a); cnt2_in = 8'(b);
    q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    #1;
    if (q.size() != 0) begin
      cur = q.pop_front();
      chk(cur.nm, "done", {15'd0, done}, {15'd0, cur.d});
      chk(cur.nm, "fail", {15'd0, fail}, {15'd0, cur.f});
      chk(cur.nm, "mismatch", {15'd0, mismatch}, {15'd0, cur.m});
      chk(cur.nm, "err_count", {12'd0, err_count}, {12'd0, cur.e});
      chk(cur.nm, "sample_count", sample_count, cur.c);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 0, mk("reset", 0, 0, 0, 0, 0));
    for (int i = 0; i < 105; i++) step(1, 0, i, 2 * i, mk("clean", i == 104, 0, 0, 0, i + 1));
    step(1, 0, 3, 3, mk("done_hold", 1, 0, 0, 0, 105));
    step(0, 1, 0, 0, mk("clear_done", 0, 0, 0, 0, 0));
    step(1, 0, 254, 252, mk("wrap", 0, 0, 0, 0, 1));
    step(1, 0, 255, 254, mk("wrap", 0, 0, 0, 0, 2));
    step(1, 0, 0, 0, mk("wrap", 0, 0, 0, 0, 3));
    step(1, 0, 1, 2, mk("wrap", 0, 0, 0, 0, 4));
    step(0, 1, 0, 0, mk("clear", 0, 0, 0, 0, 0));
    step(1, 0, 5, 20, mk("glitch", 0, 0, 0, 0, 1));
    step(1, 0, 6, 22, mk("glitch", 0, 0, 0, 0, 2));
    step(1, 0, 9, 24, mk("glitch_hit", 0, 0, 1, 1, 3));
    step(1, 0, 10, 26, mk("glitch_resync", 0, 0, 0, 1, 4));
    step(1, 0, 11, 28, mk("glitch_resync", 0, 0, 0, 1, 5));
    step(0, 1, 0, 0, mk("clear", 0, 0, 0, 0, 0));
    step(1, 0, 0, 200, mk("fail_seed", 0, 0, 0, 0, 1));
    step(1, 0, 1, 205, mk("fail_e1", 0, 0, 1, 1, 2));
    step(1, 0, 2, 209, mk("fail_e2", 0, 0, 1, 2, 3));
    step(1, 0, 3, 213, mk("fail_e3", 0, 0, 1, 3, 4));
    step(1, 0, 4, 208, mk("fail_wins", 0, 1, 1, 4, 5));
    step(1, 0, 5, 210, mk("fail_hold", 0, 1, 0, 4, 5));
    step(1, 0, 9, 99, mk("fail_hold", 0, 1, 0, 4, 5));
    step(0, 1, 0, 0, mk("clear_fail", 0, 0, 0, 0, 0));
    step(1, 0, 7, 208, mk("seed_target", 1, 0, 0, 0, 1));
    step(0, 1, 0, 0, mk("clear", 0, 0, 0, 0, 0));
    step(1, 0, 0, 8, mk("gap", 0, 0, 0, 0, 1));
    step(1, 0, 1, 10, mk("gap", 0, 0, 0, 0, 2));
    for (int i = 0; i < 3; i++) step(0, 0, 99, 77, mk("gap_idle", 0, 0, 0, 0, 2));
    step(1, 0, 2, 12, mk("gap_resume", 0, 0, 0, 0, 3));
    step(1, 1, 3, 14, mk("clear_prio", 0, 0, 0, 0, 0));
    step(1, 0, 100, 100, mk("reseed", 0, 0, 0, 0, 1));
    step(1, 0, 101, 102, mk("reseed", 0, 0, 0, 0, 2));
    step(1, 0, 110, 104, mk("pre_rst_err", 0, 0, 1, 1, 3));
    @(posedge clk);
    #3;
    q.push_back(mk("async_rst", 0, 0, 0, 0, 0));
    rst = 1'b1;
    sample_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 50, 60, mk("post_rst", 0, 0, 0, 0, 1));
    step(1, 0, 51, 62, mk("post_rst", 0, 0, 0, 0, 2));
    step(0, 0, 0, 0, mk("post_rst_idle", 0, 0, 0, 0, 2));
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Consumer/checker on the far side of the dual free-running counter interface (cnt1/cnt2, 8 bit).
- Samples both counter buses every enabled clock, predicts the next value of each, and flags mismatches.
- Raises a sticky done when counter 2 reaches a programmed target.
- Synthesizable; used in mixed-language benches and in silicon self-test, replacing ad-hoc display/finish checking.

Parameters:
- WIDTH, 8, bit width of each counter bus.
- STEP1, 1, expected per-sample increment of cnt1 (mod 2^WIDTH).
- STEP2, 2, expected per-sample increment of cnt2 (mod 2^WIDTH).
- TARGET2, 208, cnt2 value that completes the check.
- MAX_ERR, 4, error count that forces FAIL.
- ERR_W, 4, width of err_count; must satisfy 2^ERR_W-1 >= MAX_ERR.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- sample_en  in  1  cnt1_in/cnt2_in valid this cycle.
- clear  in  1  synchronous restart to IDLE; counters and flags cleared.
- cnt1_in  in  WIDTH  observed counter 1.
- cnt2_in  in  WIDTH  observed counter 2.
- done  out  1  sticky: TARGET2 reached with no pending mismatch.
- fail  out  1  sticky: err_count reached MAX_ERR.
- mismatch  out  1  one-cycle pulse, registered, on any lane mismatch.
- err_count  out  ERR_W  saturating mismatch count.
- sample_count  out  16  samples accepted since IDLE; saturates at 16'hFFFF.

Behaviour:
- Reset values: done=0, fail=0, mismatch=0, err_count=0, sample_count=0, expected regs=0, state=IDLE.
- All outputs registered; response latency is 1 clk after the sampling edge.
- States: IDLE, TRACK, DONE, FAIL.
- IDLE: on sample_en, seed exp1=cnt1_in+STEP1 and exp2=cnt2_in+STEP2 (mod 2^WIDTH); sample_count=1; go TRACK. No comparison on the seed sample. If the seed cnt2_in==TARGET2, go DONE directly.
- TRACK, sample_en=1:
  - Compare each lane.
  - Mismatch on either lane: mismatch=1 next cycle, err_count+1 (saturating), resync exp=observed+STEP so a single glitch produces exactly one error.
  - Match: exp += STEP.
  - sample_count increments on every accepted sample.
- TRACK, sample_en=0: hold all state; mismatch=0.
- Transitions out of TRACK:
  - err_count reaching MAX_ERR: go FAIL.
  - cnt2_in==TARGET2 with both lanes matching: go DONE.
  - If both occur on the same sample, FAIL wins.
  - cnt2_in==TARGET2 with a mismatch: counted as an error; no DONE.
- Wrap-around: 255 -> 0 (STEP1=1) and 254 -> 0 (STEP2=2) are valid, not errors.
- DONE / FAIL: absorbing; samples ignored; counters frozen; exit only via clear or rst.
- clear: takes priority over sample_en in the same cycle; returns to IDLE, zeroes all outputs.
- rst asserted mid-operation: all outputs go to reset values immediately (async), without waiting for a clock edge.

Optional Feature:
- Macro COUNTER_CHECKER_CAPTURE_EN.
- Defined:
  - Adds outputs first_bad_exp1, first_bad_obs1, first_bad_exp2, first_bad_obs2 (WIDTH each).
  - Captured on the first mismatch after IDLE, held until clear or rst; reset value 0.
- Undefined: ports and registers absent; no other behavioural change.

Decomposition:
- Package counter_checker_pkg:
  - State enum (IDLE, TRACK, DONE, FAIL).
  - Default WIDTH/ERR_W constants.
  - Sample-count width constant (16).
- Sub-module counter_track_lane, instantiated twice (STEP1, STEP2):
  - Holds the expected register; seeds and advances it.
  - Outputs a per-lane mismatch.
- Top-level owns the FSM, error/sample counters and sticky flags.

Test Plan:
- Clean run: cnt1 0,1,2,... and cnt2 0,2,4,... every clk -> no mismatch; done=1 one clk after the cnt2=208 sample; sample_count=105; err_count=0.
- Wrap: seed cnt1=254, cnt2=252 -> cnt1 wraps 255,0,1 and cnt2 wraps 254,0 -> no mismatch.
- Single glitch: cnt1 sequence 5,6,9,10 -> one mismatch pulse; err_count=1; later samples match (resync).
- Fail: 4 consecutive cnt2 errors with MAX_ERR=4 -> fail=1 after the 4th; state FAIL; further samples ignored; err_count stays 4.
- Sample gaps: sample_en low 3 clks between cnt2=10 and cnt2=12 -> no error; sample_count unchanged during the gap.
- Reset/clear: assert rst mid-TRACK between edges -> outputs 0 immediately; clear in DONE -> IDLE; next sample re-seeds.
